led_fade_drv: RTL



---
 rtl/led_fade_drv.sv | 97 +++++++++
 1 files changed

// File: rtl/led_fade_drv.sv
// PWM brightness/fade driver for four LED channels; led_out is registered one cycle after its pcnt compare.
// Optional macro LED_FADE_EN enables the linear duty ramp; without it duty jumps to target at each period end.
module led_fade_drv #(
  parameter int PWM_BITS = 4,
  parameter int STEP_DIV = 3
) (
  input  logic                sclk,
  input  logic                s_rst_n,
  input  logic [3:0]          led_in,
  input  logic [PWM_BITS-1:0] bright,
  output logic [3:0]          led_out
);

  logic [PWM_BITS-1:0] pcnt_q;
  logic [PWM_BITS-1:0] pcnt_d;
  logic [PWM_BITS-1:0] duty_q [4];
  logic [PWM_BITS-1:0] duty_d [4];
  logic [PWM_BITS-1:0] target [4];
  logic [3:0]          led_q;
  logic [3:0]          led_d;
  logic                period_end;
  logic                step;

  assign pcnt_d     = pcnt_q + 1'b1;
  assign period_end = &pcnt_q;

`ifdef LED_FADE_EN
  localparam int SW = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;

  logic [SW-1:0] scnt_q;
  logic [SW-1:0] scnt_d;

  assign step = period_end && (scnt_q == SW'(STEP_DIV));

  always_comb begin
    scnt_d = scnt_q;
    if (period_end) begin
      scnt_d = (scnt_q == SW'(STEP_DIV)) ? '0 : scnt_q + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      scnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
    end
  end
`else
  assign step = period_end;
`endif

  // Duty only moves at period_end so a new value always starts with a full period.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      target[i] = led_in[i] ? bright : '0;
      duty_d[i] = duty_q[i];
      if (step) begin
`ifdef LED_FADE_EN
        if (duty_q[i] < target[i]) begin
          duty_d[i] = duty_q[i] + 1'b1;
        end else if (duty_q[i] > target[i]) begin
          duty_d[i] = duty_q[i] - 1'b1;
        end
`else
        duty_d[i] = target[i];
`endif
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < 4; i++) begin
      led_d[i] = (pcnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      pcnt_q <= '0;
      led_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      pcnt_q <= pcnt_d;
      led_q  <= led_d;
      for (int i = 0; i < 4; i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign led_out = led_q;

endmodule
